mem_port_master: RTL and testbench

- Burst initiator that drives the single-port synchronous SRAM interface of the MemGen_* wrappers (chip_en, addr, rd_en, rd_data, wr_en, wr_data).
- Converts a valid/ready command stream plus a write-data stream into per-beat memory accesses, and returns read data on a valid/ready response stream through a small buffered FIFO.
- Sits between DMA/CPU-side logic and a banked memory wrapper. It enforces the wrapper's bank-select rule on read data return.

---
 rtl/mem_port_master.sv | 170 +++++++++++++++++
 tb/tb_mem_port_master.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_master.sv
// Burst master for a single-port banked SRAM wrapper: cmd/wdata streams in, read data out via a response FIFO.
// Latency: port access one cycle after the handshake/issue; read data enters the FIFO two cycles after issue.
// Backpressure: reads are issued only against free FIFO credit; wdata_ready and cmd_ready follow the FSM state.
module mem_port_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14,
    parameter int BANK_LSB   = 10,
    parameter int LEN_WIDTH  = 8,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic                  mem_chip_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  mem_wr_en,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  busy
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 2;

    typedef enum logic [1:0] {IDLE, WR, RD, RD_DRAIN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [LEN_WIDTH-1:0]  beats_left;
    logic                  last_beat;
    logic                  port_last;
    logic                  cap_vld;
    logic                  cap_last;

    logic [DATA_WIDTH:0]   fifo_mem [RSP_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         fifo_count;

    logic                  port_rd;
    logic [CW-1:0]         credit_used;
    logic                  can_issue;
    logic                  push;
    logic                  pop;

    assign port_rd     = mem_chip_en & mem_rd_en;
    // Reads still in the pipe (on the port or being captured) already own a FIFO slot.
    assign credit_used = fifo_count + CW'(port_rd) + CW'(cap_vld);
    assign can_issue   = (credit_used < CW'(RSP_DEPTH)) &&
                         (!port_rd || next_addr[ADDR_WIDTH-1:BANK_LSB] == mem_addr[ADDR_WIDTH-1:BANK_LSB]);

    assign cmd_ready   = (state == IDLE);
    assign wdata_ready = (state == WR);
    assign busy        = (state != IDLE);

    assign push        = cap_vld;
    assign pop         = rsp_valid & rsp_ready;
    assign rsp_valid   = (fifo_count != '0);
    assign {rsp_last, rsp_data} = fifo_mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            mem_chip_en <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            next_addr   <= '0;
            beats_left  <= '0;
            last_beat   <= 1'b0;
            port_last   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mem_chip_en <= 1'b0;
                    mem_rd_en   <= 1'b0;
                    mem_wr_en   <= 1'b0;
                    port_last   <= 1'b0;
                    if (cmd_valid) begin
                        next_addr  <= cmd_addr;
                        beats_left <= cmd_len;
                        last_beat  <= (cmd_len == '0);
                        state      <= cmd_write ? WR : RD;
                    end
                end
                WR: begin
                    mem_rd_en <= 1'b0;
                    port_last <= 1'b0;
                    if (wdata_valid) begin
                        mem_chip_en <= 1'b1;
                        mem_wr_en   <= 1'b1;
                        mem_addr    <= next_addr;
                        mem_wr_data <= wdata;
                        next_addr   <= next_addr + 1'b1;
                        beats_left  <= beats_left - 1'b1;
                        last_beat   <= (beats_left == LEN_WIDTH'(1));
                        if (last_beat) state <= IDLE;
                    end else begin
                        mem_chip_en <= 1'b0;
                        mem_wr_en   <= 1'b0;
                    end
                end
                RD: begin
                    mem_wr_en <= 1'b0;
                    if (can_issue) begin
                        mem_chip_en <= 1'b1;
                        mem_rd_en   <= 1'b1;
                        mem_addr    <= next_addr;
                        port_last   <= last_beat;
                        next_addr   <= next_addr + 1'b1;
                        beats_left  <= beats_left - 1'b1;
                        last_beat   <= (beats_left == LEN_WIDTH'(1));
                        if (last_beat) state <= RD_DRAIN;
                    end else begin
                        // A read just on the port needs chip_en and its bank held while its data returns.
                        mem_chip_en <= port_rd;
                        mem_rd_en   <= 1'b0;
                        port_last   <= 1'b0;
                    end
                end
                RD_DRAIN: begin
                    mem_chip_en <= 1'b1;
                    mem_rd_en   <= 1'b0;
                    mem_wr_en   <= 1'b0;
                    port_last   <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cap_vld    <= 1'b0;
            cap_last   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            cap_vld    <= port_rd;
            cap_last   <= port_rd & port_last;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= {cap_last, mem_rd_data};
    end

    assert property (@(posedge clock) disable iff (!reset_n)
        !(push && !pop && fifo_count == CW'(RSP_DEPTH)));
    assert property (@(posedge clock) disable iff (!reset_n)
        !(mem_rd_en && mem_wr_en));

endmodule

// File: tb/tb_mem_port_master.sv
// Randomised and directed bench for mem_port_master with an SRAM model and a transaction-level scoreboard.
module tb_mem_port_master;
    localparam int DW = 32, AW = 14, LW = 8, DEPTH = 4, BLSB = 10;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          cmd_valid, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          cmd_ready;
    logic          wdata_valid, wdata_ready;
    logic [DW-1:0] wdata;
    logic          rsp_valid, rsp_ready, rsp_last;
    logic [DW-1:0] rsp_data;
    logic          mem_chip_en, mem_rd_en, mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data, mem_wr_data;
    logic          busy;

    mem_port_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_LSB(BLSB), .LEN_WIDTH(LW), .RSP_DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .mem_chip_en(mem_chip_en), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .busy(busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { logic [DW-1:0] d; logic last; } rsp_t;
    typedef struct { int c; logic [AW-1:0] a; logic [DW-1:0] d; } wlog_t;
    typedef struct { int c; logic rd; logic [AW-1:0] a; } plog_t;
    typedef struct { int c; logic [DW-1:0] d; logic last; } rlog_t;

    logic [DW-1:0] ref_mem [1 << AW];
    logic [DW-1:0] sram    [1 << AW];
    rsp_t          exp_rsp [$];
    logic [AW-1:0] exp_rd_addr [$];
    wlog_t         wr_log [$];
    plog_t         port_log [$];
    rlog_t         rsp_log [$];
    logic          prev_rd = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic          exp_wr_pend = 1'b0;
    logic [AW-1:0] exp_wr_a = '0, m_wr_addr = '0;
    logic [DW-1:0] exp_wr_d = '0;
    int            outstanding = 0;
    int            rd_count = 0;

    // Compare process: SRAM model, port rules and transaction scoreboard, all evaluated mid-cycle.
    always @(negedge clock) begin
        wlog_t wl; plog_t pl; rlog_t rl; rsp_t er; rsp_t nr; logic [AW-1:0] a;
        cyc++;
        if (cyc == 1) begin
            for (int i = 0; i < (1 << AW); i++) begin
                ref_mem[i] = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
                sram[i]    = ref_mem[i];
            end
        end
        if (!reset_n) begin
            exp_rsp.delete(); exp_rd_addr.delete();
            prev_rd = 1'b0; exp_wr_pend = 1'b0; outstanding = 0;
            mem_rd_data = $urandom;
        end else begin
            chk("rd_wr_exclusive", 32'(mem_rd_en & mem_wr_en), 0);
            if (prev_rd) begin
                chk("bank_hold_chip_en", 32'(mem_chip_en), 1);
                chk("bank_hold_bank", 32'(mem_addr[AW-1:BLSB]), 32'(prev_addr[AW-1:BLSB]));
            end
            if (exp_wr_pend) begin
                chk("port_wr_strobe", 32'(mem_chip_en & mem_wr_en & ~mem_rd_en), 1);
                chk("port_wr_addr", 32'(mem_addr), 32'(exp_wr_a));
                chk("port_wr_data", mem_wr_data, exp_wr_d);
                wl.c = cyc; wl.a = mem_addr; wl.d = mem_wr_data;
                wr_log.push_back(wl);
            end else begin
                chk("no_spurious_wr", 32'(mem_chip_en & mem_wr_en), 0);
            end
            if (mem_chip_en && mem_wr_en) sram[mem_addr] = mem_wr_data;
            mem_rd_data = prev_rd ? sram[prev_addr] : $urandom;
            if (mem_chip_en && mem_rd_en) begin
                chk("rd_pending", 32'(exp_rd_addr.size() != 0), 1);
                if (exp_rd_addr.size() != 0) chk("port_rd_addr", 32'(mem_addr), 32'(exp_rd_addr.pop_front()));
                outstanding++;
                rd_count++;
                chk("credit_bound", 32'(outstanding <= DEPTH), 1);
            end
            if (mem_chip_en && !mem_wr_en) begin
                pl.c = cyc; pl.rd = mem_rd_en; pl.a = mem_addr;
                port_log.push_back(pl);
            end
            prev_rd   = mem_chip_en & mem_rd_en;
            prev_addr = mem_addr;
            if (rsp_valid && rsp_ready) begin
                chk("rsp_pending", 32'(exp_rsp.size() != 0), 1);
                if (exp_rsp.size() != 0) begin
                    er = exp_rsp.pop_front();
                    chk("rsp_data", rsp_data, er.d);
                    chk("rsp_last", 32'(rsp_last), 32'(er.last));
                end
                outstanding--;
                rl.c = cyc; rl.d = rsp_data; rl.last = rsp_last;
                rsp_log.push_back(rl);
            end
            exp_wr_pend = 1'b0;
            if (wdata_valid && wdata_ready) begin
                exp_wr_pend = 1'b1; exp_wr_a = m_wr_addr; exp_wr_d = wdata;
                ref_mem[m_wr_addr] = wdata;
                m_wr_addr = m_wr_addr + 1'b1;
            end
            if (cmd_valid && cmd_ready) begin
                if (cmd_write) m_wr_addr = cmd_addr;
                else begin
                    for (int i = 0; i <= int'(cmd_len); i++) begin
                        a = cmd_addr + AW'(i);
                        exp_rd_addr.push_back(a);
                        nr.d = ref_mem[a]; nr.last = (i == int'(cmd_len));
                        exp_rsp.push_back(nr);
                    end
                end
            end
        end
    end

    int rsp_mode = 1;  // 0: stall, 1: always ready, 2: random
    always @(posedge clock) begin
        #2;
        rsp_ready = (rsp_mode == 0) ? 1'b0 : (rsp_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    logic [DW-1:0] wbuf [64];

    task automatic do_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
        while (!cmd_ready && n < 3000) begin @(posedge clock); #1; n++; end
        chk("cmd_accept", 32'(cmd_ready), 1);
        @(posedge clock); #1;
        cmd_valid = 1'b0; cmd_addr = AW'($urandom); cmd_len = LW'($urandom);
    endtask

    task automatic do_wdata(input int last_idx, input int gap);
        for (int i = 0; i <= last_idx; i++) begin
            int g, n;
            g = (gap == 1) ? ((i > 0) ? 1 : 0) : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
            wdata_valid = 1'b0;
            repeat (g) begin @(posedge clock); #1; end
            wdata_valid = 1'b1; wdata = wbuf[i];
            n = 0;
            while (!wdata_ready && n < 100) begin @(posedge clock); #1; n++; end
            chk("wdata_accept", 32'(wdata_ready), 1);
            @(posedge clock); #1;
        end
        wdata_valid = 1'b0; wdata = $urandom;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((busy || rsp_valid || exp_rsp.size() != 0) && n < 3000) begin @(posedge clock); #1; n++; end
        chk("drain_busy", 32'(busy), 0);
        chk("drain_pending", exp_rsp.size(), 0);
        repeat (2) begin @(posedge clock); #1; end
    endtask

    logic [AW-1:0] t3_a [5];
    logic          t3_rd [5];

    initial begin
        int m, mp, mc, len, sel;
        logic [AW-1:0] a;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
        wdata_valid = 0; wdata = 0; reset_n = 0;
        t3_a  = '{14'h03FE, 14'h03FF, 14'h03FF, 14'h0400, 14'h0401};
        t3_rd = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        repeat (3) @(posedge clock); #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_wdata_ready", 32'(wdata_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_chip_en", 32'(mem_chip_en), 0);
        chk("rst_rd_wr_en", 32'({mem_rd_en, mem_wr_en}), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wr_data", mem_wr_data, 0);
        reset_n = 1; @(posedge clock); #1;

        // Contiguous write burst
        m = wr_log.size();
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
        do_cmd(1'b1, 14'h0010, 8'd3);
        chk("t1_busy_during", 32'(busy), 1);
        do_wdata(3, 0);
        chk("t1_busy_fall", 32'(busy), 0);
        wait_done();
        chk("t1_count", wr_log.size() - m, 4);
        if (wr_log.size() >= m + 4)
            for (int i = 0; i < 4; i++) begin
                chk("t1_addr", 32'(wr_log[m+i].a), 32'h10 + 32'(i));
                chk("t1_data", wr_log[m+i].d, 32'hA0 + 32'(i));
                chk("t1_consecutive", wr_log[m+i].c - wr_log[m].c, i);
            end

        // Read back, always ready
        rsp_mode = 1; m = rsp_log.size();
        do_cmd(1'b0, 14'h0010, 8'd3);
        wait_done();
        chk("t2_count", rsp_log.size() - m, 4);
        if (rsp_log.size() >= m + 4)
            for (int i = 0; i < 4; i++) begin
                chk("t2_data", rsp_log[m+i].d, 32'hA0 + 32'(i));
                chk("t2_last", 32'(rsp_log[m+i].last), (i == 3) ? 1 : 0);
                chk("t2_no_bubble", rsp_log[m+i].c - rsp_log[m].c, i);
            end

        // Bank crossing costs one hold cycle
        mp = port_log.size(); m = rsp_log.size();
        do_cmd(1'b0, 14'h03FE, 8'd3);
        wait_done();
        chk("t3_port_cycles", port_log.size() - mp, 6);
        if (port_log.size() >= mp + 5)
            for (int i = 0; i < 5; i++) begin
                chk("t3_port_addr", 32'(port_log[mp+i].a), 32'(t3_a[i]));
                chk("t3_port_rd", 32'(port_log[mp+i].rd), 32'(t3_rd[i]));
                chk("t3_port_contig", port_log[mp+i].c - port_log[mp].c, i);
            end
        chk("t3_rsp_count", rsp_log.size() - m, 4);

        // Credit stall with consumer blocked
        rsp_mode = 0; mc = rd_count; m = rsp_log.size();
        do_cmd(1'b0, 14'h0000, 8'd15);
        repeat (30) @(posedge clock); #1;
        chk("t4_reads_stalled", rd_count - mc, 4);
        chk("t4_rsp_valid", 32'(rsp_valid), 1);
        chk("t4_busy", 32'(busy), 1);
        rsp_mode = 1;
        wait_done();
        chk("t4_reads_total", rd_count - mc, 16);
        chk("t4_rsp_total", rsp_log.size() - m, 16);

        // Write wrapping past the top address with gaps
        m = wr_log.size(); wbuf[0] = $urandom; wbuf[1] = $urandom;
        do_cmd(1'b1, 14'h3FFF, 8'd1);
        do_wdata(1, 1);
        wait_done();
        chk("t5_count", wr_log.size() - m, 2);
        if (wr_log.size() >= m + 2) begin
            chk("t5_addr0", 32'(wr_log[m].a), 32'h3FFF);
            chk("t5_addr1", 32'(wr_log[m+1].a), 32'h0000);
            chk("t5_data1", wr_log[m+1].d, wbuf[1]);
            chk("t5_gap", wr_log[m+1].c - wr_log[m].c, 2);
        end

        // Asynchronous reset in the middle of a read burst
        rsp_mode = 2;
        do_cmd(1'b0, 14'h0100, 8'd31);
        repeat (6) @(posedge clock); #2;
        chk("t6_pre_busy", 32'(busy), 1);
        reset_n = 0; #1;
        chk("t6_chip_en", 32'(mem_chip_en), 0);
        chk("t6_rd_wr_en", 32'({mem_rd_en, mem_wr_en}), 0);
        chk("t6_addr", 32'(mem_addr), 0);
        chk("t6_wr_data", mem_wr_data, 0);
        chk("t6_rsp_valid", 32'(rsp_valid), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_cmd_ready", 32'(cmd_ready), 1);
        @(posedge clock); #1;
        repeat (2) @(posedge clock); #1;
        reset_n = 1; @(posedge clock); #1;
        m = rsp_log.size();
        for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
        do_cmd(1'b1, 14'h0200, 8'd2);
        do_wdata(2, 2);
        do_cmd(1'b0, 14'h0200, 8'd2);
        wait_done();
        chk("t6_fresh_count", rsp_log.size() - m, 3);
        if (rsp_log.size() >= m + 3)
            for (int i = 0; i < 3; i++) chk("t6_fresh_data", rsp_log[m+i].d, wbuf[i]);

        // Randomised traffic against the scoreboard
        rsp_mode = 2;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 2);
            a = (sel == 0) ? AW'($urandom) :
                (sel == 1) ? AW'({4'($urandom), 10'h3FF} - AW'($urandom_range(0, 3))) :
                             AW'(14'h3FFF - AW'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) begin
                len = $urandom_range(0, 7);
                for (int i = 0; i <= len; i++) wbuf[i] = $urandom;
                do_cmd(1'b1, a, LW'(len));
                do_wdata(len, $urandom_range(0, 2));
            end else begin
                len = $urandom_range(0, 20);
                do_cmd(1'b0, a, LW'(len));
            end
        end
        wait_done();
        chk("final_rd_addr_left", exp_rd_addr.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
